// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer feeding a 1-bit ALU slice, LSB first, with carry chaining.
// Optional zero flag output enabled by defining ALU_SERIAL_ZFLAG_EN.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             ERR,
    output logic [2:0]       SL_M,
    output logic             SL_A,
    output logic             SL_B,
    output logic             SL_CI,
`ifdef ALU_SERIAL_ZFLAG_EN
    output logic             ZERO,
`endif
    input  logic             SL_X,
    input  logic             SL_CO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ALU_SERIAL_ZFLAG_EN
    logic             zero_q, zero_d;
`endif

    logic [WIDTH-1:0] res_shift;
    logic             carry_nxt;
    logic             last_bit;

    assign res_shift = {SL_X, result_q[WIDTH-1:1]};
    assign carry_nxt = SL_CO & (op_q == 3'd0);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        op_d     = op_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef ALU_SERIAL_ZFLAG_EN
        zero_d   = zero_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    sa_d     = OPA;
                    sb_d     = OPB;
                    op_d     = OP;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (OP <= 3'd4) begin
                        m_d     = OP;
                        state_d = S_SHIFT;
`ifdef ALU_SERIAL_ZFLAG_EN
                        zero_d  = 1'b0;
`endif
                    end else begin
                        // operand bits are dropped so the slice sees no activity
                        sa_d    = '0;
                        sb_d    = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_FIN;
`ifdef ALU_SERIAL_ZFLAG_EN
                        zero_d  = 1'b1;
`endif
                    end
                end
            end
            S_SHIFT: begin
                result_d = res_shift;
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                carry_d  = carry_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    m_d     = 3'd0;
                    cout_d  = carry_nxt;
                    done_d  = 1'b1;
                    state_d = S_FIN;
`ifdef ALU_SERIAL_ZFLAG_EN
                    zero_d  = (res_shift == '0);
`endif
                end
            end
            S_FIN: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            op_q     <= 3'd0;
            m_q      <= 3'd0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SERIAL_ZFLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            op_q     <= op_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_SERIAL_ZFLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign ERR    = err_q;
    assign SL_M   = m_q;
    assign SL_A   = sa_q[0];
    assign SL_B   = sb_q[0];
    assign SL_CI  = carry_q;
`ifdef ALU_SERIAL_ZFLAG_EN
    assign ZERO   = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl: slice model, reference scoreboard, directed and random runs.
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [2:0]   OP = 3'd0;
    logic [W-1:0] OPA = '0;
    logic [W-1:0] OPB = '0;
    logic         BUSY, DONE, COUT, ERR;
    logic [W-1:0] RESULT;
    logic [2:0]   SL_M;
    logic         SL_A, SL_B, SL_CI;
    logic         SL_X, SL_CO;
`ifdef ALU_SERIAL_ZFLAG_EN
    logic         ZERO;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .OPA(OPA), .OPB(OPB), .BUSY(BUSY), .DONE(DONE),
        .RESULT(RESULT), .COUT(COUT), .ERR(ERR),
        .SL_M(SL_M), .SL_A(SL_A), .SL_B(SL_B), .SL_CI(SL_CI),
`ifdef ALU_SERIAL_ZFLAG_EN
        .ZERO(ZERO),
`endif
        .SL_X(SL_X), .SL_CO(SL_CO)
    );

    always #5 CLK = ~CLK;

    // 1-bit ALU slice
    always_comb begin
        SL_X  = 1'b0;
        SL_CO = 1'b0;
        case (SL_M)
            3'd0: begin
                SL_X  = SL_A ^ SL_B ^ SL_CI;
                SL_CO = (SL_A & SL_B) | (SL_CI & (SL_A ^ SL_B));
            end
            3'd1: SL_X = SL_A & SL_B;
            3'd2: SL_X = SL_A | SL_B;
            3'd3: SL_X = SL_A ^ SL_B;
            3'd4: SL_X = ~(SL_A ^ SL_B);
            default: ;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_cout(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic [2:0] op);
        int s;
        s = int'(a) + int'(b);
        return (op == 3'd0) && (s >= (1 << W));
    endfunction

    function automatic logic carry_into(input logic [W-1:0] a,
                                        input logic [W-1:0] b, input int k);
        int m;
        m = (1 << k) - 1;
        return (((int'(a) & m) + (int'(b) & m)) >> k) & 1;
    endfunction

    // reference model: m_ph counts cycles since acceptance, 0 = idle
    int           m_ph = 0;
    int           m_len = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [2:0]   m_op = 3'd0;
    logic [W-1:0] m_hres = '0;
    logic         m_hcout = 1'b0;
    logic         m_herr = 1'b0;
    logic         m_hzero = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_ph    <= 0;
            m_len   <= 0;
            m_op    <= 3'd0;
            m_hres  <= '0;
            m_hcout <= 1'b0;
            m_herr  <= 1'b0;
            m_hzero <= 1'b0;
        end else if (m_ph == 0) begin
            if (START) begin
                m_a     <= OPA;
                m_b     <= OPB;
                m_op    <= OP;
                m_ph    <= 1;
                m_len   <= (OP <= 3'd4) ? W + 1 : 1;
                m_hres  <= ref_res(OPA, OPB, OP);
                m_hcout <= ref_cout(OPA, OPB, OP);
                m_herr  <= (OP > 3'd4);
                m_hzero <= (ref_res(OPA, OPB, OP) == '0);
            end
        end else if (m_ph == m_len) begin
            m_ph <= 0;
        end else begin
            m_ph <= m_ph + 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 32'(BUSY), 32'(m_ph != 0));
            check("done", 32'(DONE), 32'(m_ph != 0 && m_ph == m_len));
            check("sl_m", 32'(SL_M),
                  (m_op <= 3'd4 && m_ph >= 1 && m_ph <= W) ? 32'(m_op) : 0);
            if (m_op <= 3'd4 && m_ph >= 1 && m_ph <= W) begin
                check("sl_a", 32'(SL_A), 32'(m_a[m_ph-1]));
                check("sl_b", 32'(SL_B), 32'(m_b[m_ph-1]));
                check("sl_ci", 32'(SL_CI), (m_op == 3'd0) ?
                      32'(carry_into(m_a, m_b, m_ph - 1)) : 0);
            end
            if (m_ph == 0 || m_ph == m_len) begin
                check("result", 32'(RESULT), 32'(m_hres));
                check("cout", 32'(COUT), 32'(m_hcout));
                check("err", 32'(ERR), 32'(m_herr));
`ifdef ALU_SERIAL_ZFLAG_EN
                check("zero", 32'(ZERO), 32'(m_hzero));
`endif
            end
        end
    end

    task automatic reset_vals(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 0);
        check({tag, "_done"}, 32'(DONE), 0);
        check({tag, "_result"}, 32'(RESULT), 0);
        check({tag, "_cout"}, 32'(COUT), 0);
        check({tag, "_err"}, 32'(ERR), 0);
        check({tag, "_sl_m"}, 32'(SL_M), 0);
        check({tag, "_sl_a"}, 32'(SL_A), 0);
        check({tag, "_sl_b"}, 32'(SL_B), 0);
        check({tag, "_sl_ci"}, 32'(SL_CI), 0);
`ifdef ALU_SERIAL_ZFLAG_EN
        check({tag, "_zero"}, 32'(ZERO), 0);
`endif
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] er,
                         input logic ec, input logic ee, input int lat);
        int n;
        OPA = a;
        OPB = b;
        OP = op;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        OPA = W'($urandom);
        OPB = W'($urandom);
        OP = 3'($urandom_range(0, 7));
        n = 1;
        while (!DONE && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("lat", 32'(n), 32'(lat));
        check("d_result", 32'(RESULT), 32'(er));
        check("d_cout", 32'(COUT), 32'(ec));
        check("d_err", 32'(ERR), 32'(ee));
`ifdef ALU_SERIAL_ZFLAG_EN
        check("d_zero", 32'(ZERO), 32'(er == '0));
`endif
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        reset_vals("rst");
        chk_en = 1'b1;
        RST = 1'b0;
        @(negedge CLK);

        do_op(8'hA5, 8'h5A, 3'd0, 8'hFF, 1'b0, 1'b0, 9);
        do_op(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 9);
        do_op(8'hF0, 8'h3C, 3'd1, 8'h30, 1'b0, 1'b0, 9);
        do_op(8'hF0, 8'h0F, 3'd2, 8'hFF, 1'b0, 1'b0, 9);
        do_op(8'hF0, 8'hAA, 3'd3, 8'h5A, 1'b0, 1'b0, 9);
        do_op(8'hAA, 8'h0F, 3'd4, 8'h5A, 1'b0, 1'b0, 9);
        do_op(8'h12, 8'h34, 3'd6, 8'h00, 1'b0, 1'b1, 1);

        // START held through SHIFT and FIN; only the post-FIN one is taken
        OPA = 8'h12;
        OPB = 8'h34;
        OP = 3'd0;
        START = 1'b1;
        for (int i = 1; i <= W; i++) begin
            @(negedge CLK);
            OPA = W'($urandom);
            OPB = W'($urandom);
            OP = 3'($urandom_range(0, 7));
        end
        @(negedge CLK);
        check("ign_done", 32'(DONE), 1);
        check("ign_result", 32'(RESULT), 32'h46);
        OPA = 8'h01;
        OPB = 8'h01;
        OP = 3'd0;
        @(negedge CLK);
        check("ign_idle", 32'(BUSY), 0);
        OPA = 8'h03;
        OPB = 8'h04;
        @(negedge CLK);
        START = 1'b0;
        check("b2b_busy", 32'(BUSY), 1);
        for (int i = 0; i < 40 && !DONE; i++) @(negedge CLK);
        check("b2b_result", 32'(RESULT), 32'h07);
        @(negedge CLK);

        // reset in cycle 4 of a plus
        OPA = 8'h33;
        OPB = 8'h44;
        OP = 3'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        reset_vals("mid");
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check("no_done", 32'(DONE), 0);
        end
        do_op(8'h33, 8'h44, 3'd0, 8'h77, 1'b0, 1'b0, 9);

        for (int i = 0; i < 3000; i++) begin
            START = ($urandom_range(0, 2) == 0);
            OPA = W'($urandom);
            OPB = W'($urandom);
            OP = 3'($urandom_range(0, 7));
            RST = ($urandom_range(0, 299) == 0);
            @(negedge CLK);
        end
        RST = 1'b0;
        START = 1'b0;
        repeat (12) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequencer that drives the 1-bit ALU slice bit-serially. It captures two WIDTH-bit operands and an opcode, then presents one bit pair per clock, LSB first, to the slice. It chains the slice's carry output back into its carry input through a register and shifts the slice result into a WIDTH-bit result register. It sits directly upstream of the slice and is the slice's only source of M/A/B/Ci.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports (clock and reset are one clock, synchronous, active-high reset):
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  request; sampled only in IDLE.
- OP  in  3  opcode: 0 plus, 1 AND, 2 OR, 3 XOR, 4 XNOR; 5–7 illegal.
- OPA  in  WIDTH  operand A; captured on accepted START.
- OPB  in  WIDTH  operand B; captured on accepted START.
- BUSY  out  1  high from the cycle after an accepted START through the DONE cycle.
- DONE  out  1  one-cycle pulse; RESULT, COUT and ERR are valid on this cycle and held until the next accepted START.
- RESULT  out  WIDTH  assembled result.
- COUT  out  1  final carry for plus; 0 for all other opcodes.
- ERR  out  1  set on DONE of an illegal opcode.
- SL_M  out  3  opcode to slice; equals the latched OP during SHIFT, 0 otherwise.
- SL_A  out  1  current A bit to slice.
- SL_B  out  1  current B bit to slice.
- SL_CI  out  1  carry into slice, driven from the carry register.
- SL_X  in  1  slice result bit; combinational from SL_*.
- SL_CO  in  1  slice carry out.

## Operation
- FSM states: IDLE, SHIFT, FIN.
- **IDLE:**
  - On START=1, latch OPA/OPB into shift registers SA/SB and latch OP.
  - Clear the carry register, bit counter and RESULT; clear ERR.
  - If OP ≤ 4, go to SHIFT.
  - If OP ≥ 5, set ERR, leave RESULT=0 and go to FIN; no slice activity.
- **SHIFT (one cycle per bit):**
  - SL_A=SA[0], SL_B=SB[0], SL_CI=carry.
  - At the edge, RESULT shifts right with SL_X entering the MSB.
  - SA and SB shift right, with 0 entering the MSB.
  - If the latched OP=0, carry loads SL_CO; otherwise carry stays 0.
  - The counter increments; after the WIDTH-th bit, go to FIN.
- **FIN:** DONE=1 for exactly one cycle, BUSY=1. COUT = carry register. Next state IDLE.
- **START outside IDLE:** ignored, no queueing. START in the FIN cycle is ignored. Back-to-back operation restarts at the earliest in the cycle after FIN.
- **Operand capture:** OPA/OPB/OP changes after capture have no effect.
- **Counter width:** $clog2(WIDTH+1). Wrap is impossible because the counter is cleared at START.
- **Reset mid-operation:** returns to IDLE next edge. The current operation is abandoned with no DONE.

## Timing
- **Reset values:** BUSY=0, DONE=0, RESULT=0, COUT=0, ERR=0, SL_M=0, SL_A=0, SL_B=0, SL_CI=0, state IDLE.
- **Latency:** START accepted at edge 0; SHIFT occupies cycles 1..WIDTH; DONE is high in cycle WIDTH+1. Total WIDTH+2 cycles START-to-IDLE.
- **Illegal opcode:** DONE in cycle 1.
- **Slice path:** the slice is combinational. SL_X/SL_CO are sampled at the edge ending the same cycle the bit is presented, so there is a single-cycle path SL_* → slice → SL_X/SL_CO.
- **Outputs:** all are registered except SL_A/SL_B/SL_CI/SL_M, which are direct register bits, so there is no combinational input-to-output path.

## Configuration
- **ALU_SERIAL_ZFLAG_EN defined:**
  - Adds output ZERO (1 bit): 1 when the final RESULT is all zeros, registered, valid from DONE and held like RESULT.
  - Reset value of ZERO is 0.
  - An illegal opcode yields ZERO=1 (RESULT=0).
- **ALU_SERIAL_ZFLAG_EN not defined:** no ZERO port; no zero-detect logic.

## Test plan
Bench pairs the block with a behavioural 1-bit slice model. WIDTH=8 unless noted.
- Plus: OPA=0xA5, OPB=0x5A, OP=0 → RESULT=0xFF, COUT=0, DONE in cycle 9 after START, BUSY high cycles 1–9.
- Plus carry chain: OPA=0xFF, OPB=0x01 → RESULT=0x00, COUT=1; with ZFLAG_EN, ZERO=1.
- Logic ops with OPA=0xF0:
  - AND with OPB=0x3C → 0x30.
  - OR with OPB=0x0F → 0xFF.
  - XOR with OPB=0xAA → 0x5A.
  - XNOR: OPA=0xAA, OPB=0x0F → 0x5A.
  - COUT=0 for all four.
- START pulsed in every SHIFT cycle with different OPA → ignored; result matches the first operands; a second START in the FIN cycle is ignored, and one the cycle after FIN is accepted.
- RST asserted in cycle 4 of a plus → next cycle all outputs at reset values, no DONE. A following START runs normally.
- OP=6 → DONE in cycle 1, ERR=1, RESULT=0, COUT=0, SL_M stays 0 throughout.
